// File: rtl/par_rw_fifo.sv
// Circular FIFO taking up to PAR_WRITE words and releasing up to PAR_READ words per cycle; show-ahead read data.
// Latency: a write is visible on rd_data one cycle later; requests beyond wr_space/rd_avail are rejected whole and flagged.
module par_rw_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W     = 3,
  parameter int PAR_WRITE  = 2,
  parameter int PAR_READ   = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wr_en,
  input  logic [$clog2(PAR_WRITE+1)-1:0]     wr_cnt,
  input  logic [PAR_WRITE*DATA_WIDTH-1:0]    wr_data,
  output logic [$clog2(PAR_WRITE+1)-1:0]     wr_space,
  input  logic                               rd_en,
  input  logic [$clog2(PAR_READ+1)-1:0]      rd_cnt,
  output logic [PAR_READ*DATA_WIDTH-1:0]     rd_data,
  output logic [$clog2(PAR_READ+1)-1:0]      rd_avail,
  output logic [ADDR_W:0]                    count,
  output logic                               full,
  output logic                               empty,
  output logic                               err_ovf,
  output logic                               err_udf,
  input  logic                               err_clr
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int WCW   = $clog2(PAR_WRITE+1);
  localparam int RCW   = $clog2(PAR_READ+1);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PW_C    = (ADDR_W+1)'(PAR_WRITE);
  localparam logic [ADDR_W:0] PR_C    = (ADDR_W+1)'(PAR_READ);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]     r_wr_ptr;
  logic [ADDR_W-1:0]     r_rd_ptr;
  logic [ADDR_W:0]       r_count;
  logic                  r_err_ovf;
  logic                  r_err_udf;

  logic [ADDR_W:0]       w_free;
  logic                  w_wr_req;
  logic                  w_rd_req;
  logic                  w_wa;
  logic                  w_ra;
  logic [ADDR_W:0]       w_wr_add;
  logic [ADDR_W:0]       w_rd_sub;
  logic [PAR_READ*DATA_WIDTH-1:0] w_rd_data;

  // Space and availability come from the registered count only, so a same-cycle pop never opens write space.
  assign w_free   = DEPTH_C - r_count;
  assign wr_space = (w_free > PW_C) ? WCW'(PW_C) : WCW'(w_free);
  assign rd_avail = (r_count > PR_C) ? RCW'(PR_C) : RCW'(r_count);

  assign w_wr_req = wr_en && (wr_cnt != '0);
  assign w_rd_req = rd_en && (rd_cnt != '0);
  assign w_wa     = w_wr_req && (wr_cnt <= wr_space);
  assign w_ra     = w_rd_req && (rd_cnt <= rd_avail);
  assign w_wr_add = w_wa ? (ADDR_W+1)'(wr_cnt) : '0;
  assign w_rd_sub = w_ra ? (ADDR_W+1)'(rd_cnt) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_err_ovf <= 1'b0;
      r_err_udf <= 1'b0;
    end else begin
      if (w_wa) r_wr_ptr <= r_wr_ptr + ADDR_W'(wr_cnt);
      if (w_ra) r_rd_ptr <= r_rd_ptr + ADDR_W'(rd_cnt);
      r_count <= r_count + w_wr_add - w_rd_sub;
      if (w_wr_req && !w_wa) r_err_ovf <= 1'b1;
      else if (err_clr)      r_err_ovf <= 1'b0;
      if (w_rd_req && !w_ra) r_err_udf <= 1'b1;
      else if (err_clr)      r_err_udf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wa) begin
      for (int i = 0; i < PAR_WRITE; i++) begin
        if (WCW'(i) < wr_cnt)
          r_mem[r_wr_ptr + ADDR_W'(i)] <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Lanes beyond the occupancy read as zero rather than stale memory.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < PAR_READ; i++) begin
      if ((ADDR_W+1)'(i) < r_count)
        w_rd_data[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[r_rd_ptr + ADDR_W'(i)];
    end
  end

  assign rd_data = w_rd_data;
  assign count   = r_count;
  assign full    = (r_count == DEPTH_C);
  assign empty   = (r_count == '0);
  assign err_ovf = r_err_ovf;
  assign err_udf = r_err_udf;

endmodule

// File: tb/tb_par_rw_fifo.sv
// Bench for par_rw_fifo: directed corner cases plus random traffic, all checked against a queue-based model.
module tb_par_rw_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_cnt;
  logic [15:0] wr_data;
  logic [1:0]  wr_space;
  logic        rd_en;
  logic [2:0]  rd_cnt;
  logic [31:0] rd_data;
  logic [2:0]  rd_avail;
  logic [3:0]  count;
  logic        full;
  logic        empty;
  logic        err_ovf;
  logic        err_udf;
  logic        err_clr;

  par_rw_fifo #(.DATA_WIDTH(8), .ADDR_W(3), .PAR_WRITE(2), .PAR_READ(4)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_cnt(wr_cnt), .wr_data(wr_data), .wr_space(wr_space),
    .rd_en(rd_en), .rd_cnt(rd_cnt), .rd_data(rd_data), .rd_avail(rd_avail),
    .count(count), .full(full), .empty(empty),
    .err_ovf(err_ovf), .err_udf(err_udf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: words in FIFO order, pointer positions, sticky flags.
  byte unsigned q[$];
  int  m_wp, m_rp;
  bit  m_ovf, m_udf;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int sz;
    logic [31:0] e;
    sz = q.size();
    e = '0;
    for (int i = 0; i < 4; i++) if (i < sz) e[i*8 +: 8] = q[i];
    chk({tag, "_count"}, count, sz);
    chk({tag, "_full"}, full, sz == 8);
    chk({tag, "_empty"}, empty, sz == 0);
    chk({tag, "_space"}, wr_space, (8 - sz < 2) ? 8 - sz : 2);
    chk({tag, "_avail"}, rd_avail, (sz < 4) ? sz : 4);
    chk({tag, "_rdata"}, rd_data, e);
    chk({tag, "_ovf"}, err_ovf, m_ovf);
    chk({tag, "_udf"}, err_udf, m_udf);
  endtask

  task automatic model_reset();
    q.delete();
    m_wp = 0; m_rp = 0; m_ovf = 0; m_udf = 0;
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_cnt = 0; wr_data = 0; rd_en = 0; rd_cnt = 0; err_clr = 0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input string tag, input logic we, input logic [1:0] wc, input logic [15:0] wd,
                      input logic re, input logic [2:0] rc, input logic clr);
    int sz, sp, av;
    bit wa, ra;
    @(negedge clk);
    wr_en = we; wr_cnt = wc; wr_data = wd; rd_en = re; rd_cnt = rc; err_clr = clr;
    sz = q.size();
    sp = (8 - sz < 2) ? 8 - sz : 2;
    av = (sz < 4) ? sz : 4;
    wa = we && wc != 0 && int'(wc) <= sp;
    ra = re && rc != 0 && int'(rc) <= av;
    @(posedge clk);
    if (ra) begin
      for (int i = 0; i < int'(rc); i++) void'(q.pop_front());
      m_rp = (m_rp + int'(rc)) % 8;
    end
    if (wa) begin
      for (int i = 0; i < int'(wc); i++) q.push_back(wd[i*8 +: 8]);
      m_wp = (m_wp + int'(wc)) % 8;
    end
    if (we && wc != 0 && !wa) m_ovf = 1;
    else if (clr)             m_ovf = 0;
    if (re && rc != 0 && !ra) m_udf = 1;
    else if (clr)             m_udf = 0;
    #1;
    check_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    #1;
    model_reset();
    check_all("rst0");
    do_reset("rst");

    // Two words become visible the next cycle; upper lanes stay zero.
    step("t1_wr", 1, 2, 16'hA1A0, 0, 0, 0);
    chk("t1_lanes", rd_data, 32'h0000_A1A0);

    // Fill to full, then a single-word write must be refused.
    for (int k = 0; k < 3; k++) step("t2_fill", 1, 2, 16'(16'h1100 * (k + 2) + k), 0, 0, 0);
    chk("t2_full", full, 1'b1);
    chk("t2_space", wr_space, 2'd0);
    step("t2_ovf", 1, 1, 16'h00EE, 0, 0, 0);
    chk("t2_ovf_flag", err_ovf, 1'b1);
    chk("t2_cnt8", count, 4'd8);

    // Full FIFO, write 2 + read 4 together: write refused, read taken.
    step("t5_clr", 0, 0, 0, 0, 0, 1);
    step("t5_mix", 1, 2, 16'h5555, 1, 4, 0);
    chk("t5_cnt4", count, 4'd4);
    chk("t5_ovf", err_ovf, 1'b1);

    // Occupancy 3 with a pop of 4 is refused; then clear both flags.
    step("t4_pop1", 0, 0, 0, 1, 1, 0);
    step("t4_udf", 0, 0, 0, 1, 4, 0);
    chk("t4_udf_flag", err_udf, 1'b1);
    chk("t4_cnt3", count, 4'd3);
    step("t4_clr", 0, 0, 0, 0, 0, 1);
    chk("t4_flags", {err_ovf, err_udf}, 2'b00);

    // Walk both pointers to 7 on an empty FIFO, then write across the wrap.
    do_reset("t3_rst");
    for (int k = 0; k < 7; k++) begin
      step("t3_w", 1, 1, 16'(k), 0, 0, 0);
      step("t3_r", 0, 0, 0, 1, 1, 0);
    end
    step("t3_wrap", 1, 2, 16'hB0A7, 0, 0, 0);
    chk("t3_slot7", dut.r_mem[7], 8'hA7);
    chk("t3_slot0", dut.r_mem[0], 8'hB0);
    chk("t3_order", rd_data[15:0], 16'hB0A7);
    step("t3_rd", 0, 0, 0, 1, 2, 0);
    chk("t3_rdptr", dut.r_rd_ptr, m_rp);

    // Asynchronous reset mid-cycle with a write pending.
    do_reset("t6_pre");
    step("t6_a", 1, 2, 16'h0201, 0, 0, 0);
    step("t6_b", 1, 2, 16'h0403, 0, 0, 0);
    step("t6_c", 1, 1, 16'h0005, 0, 0, 0);
    @(negedge clk);
    wr_en = 1; wr_cnt = 2; wr_data = 16'h0706;
    #1;
    rst = 1'b1;
    #1;
    chk("t6_cnt0", count, 4'd0);
    chk("t6_empty", empty, 1'b1);
    model_reset();
    idle_inputs();
    #1;
    check_all("t6_inrst");
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 400; k++) begin
      step("rnd", 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 16'($urandom),
           1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 5)), 1'($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
